// File: rtl/max7219_chain_model_if.sv
// 3-wire MAX7219 serial bus (spi_clk/din/cs) as driven by the display driver.
// The master modport is the driver side; the slave modport is the chain model side.
interface max7219_chain_model_if;
  logic spi_clk;
  logic din;
  logic cs;

  modport master (output spi_clk, output din, output cs);
  modport slave  (input spi_clk, input din, input cs);
endinterface

// File: rtl/max7219_chain_model.sv
// Receive-side model of a daisy-chained MAX7219 string with per-device register readback.
// Define MAX7219_CODEB_EN to return Code-B decoded segment patterns on digit readback.
module max7219_chain_model #(
  parameter int N_DEV    = 4,
  parameter int SYNC_LEN = 2,
  localparam int RD_W    = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic                  clk,
  input  logic                  reset_sw,
  max7219_chain_model_if.slave  bus,
  input  logic [RD_W-1:0]       rd_dev,
  input  logic [3:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  frame_stb,
  output logic                  frame_err,
  output logic [N_DEV-1:0]      shutdown_n
);

  localparam int FRAME_BITS = 16 * N_DEV;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_LEN-1:0]   clk_sync, din_sync, cs_sync;
  logic                  spi_prev, cs_prev;
  logic                  spi_s, din_s, cs_s;
  logic                  spi_rise, cs_rise, cs_fall;
  logic [0:0]            state;
  logic [CNT_W-1:0]      bit_count;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  frame_ok;
  logic [7:0]            regs [N_DEV][16];
  logic [3:0]            w_addr [N_DEV];
  logic [7:0]            w_data [N_DEV];
  logic [4*N_DEV-1:0]    hi_nibbles_unused;
  logic [7:0]            rd_raw, rd_decode, rd_next;

  // cs synchronises to its idle (high) level so reset never fakes a cs edge.
  always_ff @(posedge clk or negedge reset_sw) begin
    if (!reset_sw) begin
      clk_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '1;
      spi_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_LEN-2:0], bus.spi_clk};
      din_sync <= {din_sync[SYNC_LEN-2:0], bus.din};
      cs_sync  <= {cs_sync[SYNC_LEN-2:0], bus.cs};
      spi_prev <= spi_s;
      cs_prev  <= cs_s;
    end
  end

  assign spi_s    = clk_sync[SYNC_LEN-1];
  assign din_s    = din_sync[SYNC_LEN-1];
  assign cs_s     = cs_sync[SYNC_LEN-1];
  assign spi_rise = spi_s & ~spi_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign frame_ok = cs_rise && (bit_count == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or negedge reset_sw) begin
    if (!reset_sw) begin
      state     <= ST_IDLE;
      bit_count <= '0;
      shift_reg <= '0;
    end else if (cs_fall) begin
      state     <= ST_SHIFT;
      bit_count <= '0;
      shift_reg <= '0;
    end else if (cs_rise) begin
      state     <= ST_IDLE;
      bit_count <= '0;
    end else if (state == ST_SHIFT && spi_rise) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], din_s};
      if (bit_count != CNT_W'(FRAME_BITS + 1))
        bit_count <= bit_count + 1'b1;
    end
  end

  always_comb begin
    for (int d = 0; d < N_DEV; d++) begin
      w_addr[d] = shift_reg[16*d+8 +: 4];
      w_data[d] = shift_reg[16*d +: 8];
      hi_nibbles_unused[4*d +: 4] = shift_reg[16*d+12 +: 4];
    end
  end

  function automatic logic addr_writable(input logic [3:0] addr);
    return !(addr == 4'h0 || addr == 4'hD || addr == 4'hE);
  endfunction

  function automatic logic [7:0] wr_mask(input logic [3:0] addr, input logic [7:0] data);
    case (addr)
      4'hA:       return {4'h0, data[3:0]};
      4'hB:       return {5'h00, data[2:0]};
      4'hC, 4'hF: return {7'h00, data[0]};
      default:    return data;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_sw) begin
    if (!reset_sw) begin
      for (int d = 0; d < N_DEV; d++)
        for (int a = 0; a < 16; a++)
          regs[d][a] <= '0;
    end else if (frame_ok) begin
      for (int d = 0; d < N_DEV; d++)
        if (addr_writable(w_addr[d]))
          regs[d][w_addr[d]] <= wr_mask(w_addr[d], w_data[d]);
    end
  end

  always_comb begin
    shutdown_n = '0;
    for (int d = 0; d < N_DEV; d++)
      shutdown_n[d] = regs[d][4'hC][0];
  end

  // Out-of-range device indices match no device and read back as zero.
  always_comb begin
    rd_raw    = '0;
    rd_decode = '0;
    for (int d = 0; d < N_DEV; d++) begin
      if (rd_dev == RD_W'(d)) begin
        rd_raw    = regs[d][rd_addr];
        rd_decode = regs[d][4'h9];
      end
    end
  end

`ifdef MAX7219_CODEB_EN
  function automatic logic [6:0] codeb_seg(input logic [3:0] code);
    case (code)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h01;  4'hB: return 7'h4F;
      4'hC: return 7'h37;  4'hD: return 7'h0E;  4'hE: return 7'h67;  default: return 7'h00;
    endcase
  endfunction

  logic [2:0] digit_idx;
  logic       is_digit;
  assign digit_idx = 3'(rd_addr - 4'd1);
  assign is_digit  = (rd_addr >= 4'h1) && (rd_addr <= 4'h8);

  always_comb begin
    rd_next = rd_raw;
    if (is_digit && rd_decode[digit_idx])
      rd_next = {rd_raw[7], codeb_seg(rd_raw[3:0])};
  end
`else
  logic [7:0] decode_unused;
  assign decode_unused = rd_decode;
  assign rd_next       = rd_raw;
`endif

  always_ff @(posedge clk or negedge reset_sw) begin
    if (!reset_sw) begin
      rd_data   <= '0;
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_data   <= rd_next;
      frame_stb <= frame_ok;
      frame_err <= cs_rise && !frame_ok;
    end
  end

endmodule

// File: tb/tb_max7219_chain_model.sv
// Directed bench for max7219_chain_model (N_DEV=4): frames, rejects, reset abort, readback.
module tb_max7219_chain_model;

  logic       clk = 1'b0;
  logic       reset_sw;
  logic [1:0] rd_dev;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_stb;
  logic       frame_err;
  logic [3:0] shutdown_n;

  max7219_chain_model_if bus ();

  max7219_chain_model #(.N_DEV(4), .SYNC_LEN(2)) dut (
    .clk        (clk),
    .reset_sw   (reset_sw),
    .bus        (bus.slave),
    .rd_dev     (rd_dev),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_stb  (frame_stb),
    .frame_err  (frame_err),
    .shutdown_n (shutdown_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int stb_count = 0;
  int err_count = 0;
  int last_stb_cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_stb) begin
      stb_count    = stb_count + 1;
      last_stb_cyc = cyc;
    end
    if (frame_err) err_count = err_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sends the top nbits of frame MSB first (zeros beyond 64), then raises cs just after a clk edge.
  task automatic applyStimulus(input logic [63:0] frame, input int nbits, output int rise_cyc);
    bus.cs = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      bus.din = (i < 64) ? frame[63-i] : 1'b0;
      #40 bus.spi_clk = 1'b1;
      #40 bus.spi_clk = 1'b0;
    end
    #40;
    @(posedge clk);
    #1;
    rise_cyc = cyc;
    bus.cs   = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic read_check(input int dev, input logic [3:0] addr, input logic [7:0] expected, input string tag);
    @(negedge clk);
    rd_dev  = 2'(dev);
    rd_addr = addr;
    @(posedge clk);
    #1;
    checkOutput(tag, 64'(rd_data), 64'(expected));
  endtask

  int s0, e0, rise;
  logic [7:0] codeb_expected;

  initial begin
    reset_sw    = 1'b0;
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b0;
    bus.din     = 1'b0;
    rd_dev      = '0;
    rd_addr     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rd_data", 64'(rd_data), 64'h0);
    checkOutput("reset frame_stb", 64'(frame_stb), 64'h0);
    checkOutput("reset frame_err", 64'(frame_err), 64'h0);
    checkOutput("reset shutdown_n", 64'(shutdown_n), 64'h0);
    @(negedge clk);
    reset_sw = 1'b1;
    repeat (3) @(posedge clk);

    // Shutdown register written on every device.
    s0 = stb_count; e0 = err_count;
    applyStimulus(64'h0C01_0C01_0C01_0C01, 64, rise);
    checkOutput("t1 stb count", 64'(stb_count - s0), 64'd1);
    checkOutput("t1 err count", 64'(err_count - e0), 64'd0);
    checkOutput("t1 stb latency", 64'(last_stb_cyc - rise), 64'd3);
    checkOutput("t1 shutdown_n", 64'(shutdown_n), 64'hF);
    for (int d = 0; d < 4; d++) read_check(d, 4'hC, 8'h01, "t1 rd shutdown");

    s0 = stb_count;
    applyStimulus(64'h0155_02AA_0A0F_0B07, 64, rise);
    checkOutput("t2 stb count", 64'(stb_count - s0), 64'd1);
    read_check(3, 4'h1, 8'h55, "t2 dev3 a1");
    read_check(2, 4'h2, 8'hAA, "t2 dev2 a2");
    read_check(1, 4'hA, 8'h0F, "t2 dev1 aA");
    read_check(0, 4'hB, 8'h07, "t2 dev0 aB");

    // Field masking, ignored address 0xD, and shutdown cleared on dev0.
    applyStimulus(64'h0AFF_0BFF_0DFF_0C00, 64, rise);
    read_check(3, 4'hA, 8'h0F, "mask dev3 aA");
    read_check(2, 4'hB, 8'h07, "mask dev2 aB");
    read_check(1, 4'hD, 8'h00, "mask dev1 aD");
    read_check(1, 4'hA, 8'h0F, "mask dev1 aA kept");
    read_check(2, 4'h2, 8'hAA, "mask dev2 a2 kept");
    checkOutput("mask shutdown_n", 64'(shutdown_n), 64'hE);

    s0 = stb_count; e0 = err_count;
    applyStimulus(64'h0C01_0C01_0C01_0C01, 63, rise);
    checkOutput("t3 err count", 64'(err_count - e0), 64'd1);
    checkOutput("t3 stb count", 64'(stb_count - s0), 64'd0);
    checkOutput("t3 shutdown_n", 64'(shutdown_n), 64'hE);
    read_check(3, 4'h1, 8'h55, "t3 dev3 a1 kept");

    // Reset in the middle of a frame.
    bus.cs = 1'b0;
    #40;
    for (int i = 0; i < 30; i++) begin
      bus.din = i[0];
      #40 bus.spi_clk = 1'b1;
      #40 bus.spi_clk = 1'b0;
    end
    reset_sw = 1'b0;
    #1;
    checkOutput("t4 async shutdown_n", 64'(shutdown_n), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_sw = 1'b1;
    repeat (5) @(posedge clk);
    read_check(3, 4'h1, 8'h00, "t4 dev3 a1 cleared");
    s0 = stb_count; e0 = err_count;
    @(posedge clk);
    #1;
    bus.cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t4 err after reset", 64'(err_count - e0), 64'd1);
    checkOutput("t4 no stb after reset", 64'(stb_count - s0), 64'd0);
    s0 = stb_count;
    applyStimulus(64'h0C01_0C01_0C01_0C01, 64, rise);
    checkOutput("t4 stb next frame", 64'(stb_count - s0), 64'd1);
    checkOutput("t4 shutdown_n", 64'(shutdown_n), 64'hF);

    // No-op word on dev1; top nibble of dev3 word is don't-care.
    applyStimulus(64'h0111_0122_0133_0144, 64, rise);
    s0 = stb_count;
    applyStimulus(64'hF155_0166_0000_0177, 64, rise);
    checkOutput("t5 stb count", 64'(stb_count - s0), 64'd1);
    read_check(3, 4'h1, 8'h55, "t5 dev3 a1");
    read_check(2, 4'h1, 8'h66, "t5 dev2 a1");
    read_check(1, 4'h1, 8'h33, "t5 dev1 a1 kept");
    read_check(0, 4'h1, 8'h77, "t5 dev0 a1");

    s0 = stb_count; e0 = err_count;
    applyStimulus(64'h0C00_0C00_0C00_0C00, 70, rise);
    checkOutput("sat err count", 64'(err_count - e0), 64'd1);
    checkOutput("sat stb count", 64'(stb_count - s0), 64'd0);
    checkOutput("sat shutdown_n", 64'(shutdown_n), 64'hF);

    applyStimulus(64'h0000_0000_0000_09FF, 64, rise);
    applyStimulus(64'h0000_0000_0000_0185, 64, rise);
`ifdef MAX7219_CODEB_EN
    codeb_expected = 8'hDB;
`else
    codeb_expected = 8'h85;
`endif
    read_check(0, 4'h1, codeb_expected, "t6 dev0 a1 decode");
    read_check(0, 4'h9, 8'hFF, "t6 dev0 decode reg");
    read_check(1, 4'h1, 8'h33, "t6 dev1 a1 raw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
